fb_scanout: RTL and testbench
=============================

// Module: fb_scanout
// PURPOSE
//  Reads the 1bpp framebuffer that SM shader programs build in memory (pixel (x,y) = byte base+y*PITCH+x/8, bit x%8).
//  Streams it out as one pixel per cycle, in raster order, on a valid/ready interface for display/capture logic.
//  Sits downstream of the streaming_multiprocessor. Started once the warp reaches EXIT.
//  Reads memory through a single-outstanding 32-bit word port.
// PARAMETERS
//  FB_WIDTH   64  pixels per row; multiple of 32; PITCH = FB_WIDTH/8 bytes
//  FB_HEIGHT  64  rows per frame
//  ADDR_W     32  memory byte-address width
// PORTS
//  clk            in   1       clock; all state on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  start          in   1       pulse: begin one frame scan (ignored while busy)
//  fb_base        in   ADDR_W  framebuffer byte base, sampled on accepted start; bits[1:0] forced 0
//  busy           out  1       frame scan in progress
//  done           out  1       1-cycle pulse after last pixel accepted
//  mem_req_valid  out  1       word read request
//  mem_req_ready  in   1       memory accepts request
//  mem_req_addr   out  ADDR_W  word byte address (4-aligned)
//  mem_rsp_valid  in   1       read data return
//  mem_rsp_data   in   32      little-endian word; bit i = pixel x%32==i
//  pix_valid      out  1       pixel available
//  pix_ready      in   1       consumer accepts pixel
//  pix_data       out  1       pixel value
//  pix_x          out  16      column
//  pix_y          out  16      row
//  pix_sof        out  1       first pixel of frame (0,0)
//  pix_eol        out  1       last pixel of row
//  pix_eof        out  1       last pixel of frame
//  frame_crc      out  32      CRC of emitted frame (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output 0; FSM=IDLE; outstanding flag cleared.
//  FSM: IDLE -start-> REQ -mem_req_ready-> WAIT -mem_rsp_valid-> EMIT -32 pixels accepted->
//       REQ (more words) | DONE.  DONE -> IDLE after 1 cycle (done=1 that cycle, busy=0).
//  busy=1 in REQ/WAIT/EMIT/DONE-entry; asserted the cycle after start accepted.
//  REQ: mem_req_valid=1; addr = base + y*PITCH + w*4 (w = word in row, 0..FB_WIDTH/32-1).
//       valid and addr held stable until ready. Handshake = valid&ready.
//  WAIT: exactly one outstanding read; any response arriving with no read outstanding is dropped.
//  EMIT: 32-bit shift register, LSB first. pix_data=sr[0]. Shift/advance only on pix_valid&pix_ready.
//        pix_valid, pix_data, pix_x, pix_y and markers are stable while pix_ready=0.
//  Counters: x wraps FB_WIDTH-1->0 with y++; eol when x==FB_WIDTH-1; eof when x,y both at max.
//            sof when x==0 && y==0.
//  Latency: start@T -> mem_req_valid@T+1; rsp@R -> pix_valid@R+1. No overlap of fetch and emit.
//  start while busy or in DONE: ignored; fb_base not resampled.
//  start in the same cycle as done: ignored.
//  Async reset mid-frame: immediate return to reset state; late mem_rsp dropped.
//  Next start scans a full frame from (0,0).
// CONFIGURATION
//  FB_SCANOUT_CRC_EN defined:
//   - CRC-32, poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first, one bit per accepted pixel, final XOR 0xFFFFFFFF.
//   - Initialised on accepted start. frame_crc updated the cycle done pulses.
//   - Held until the next accepted start; reset to 0.
//  Not defined: frame_crc tied 32'h0; no CRC logic.
// TESTING
//  1 Reset, hold rst_n=0 10 cycles -> all outputs 0, busy=0, no mem_req_valid.
//  2 FB all 0 except word@0x2000=0x00000001, start fb_base=0x2000, pix_ready=1 ->
//    4096 pixels; only (0,0)=1; sof on 1st, eol every 64th, eof on 4096th; done next cycle.
//  3 Word@0x202C = 1<<5 -> only pixel x=37,y=5 is 1.
//    Request addresses 0x2000,0x2004,...,0x21FC in order, 128 requests.
//  4 Random 50% pix_ready and 0-5 cycle mem_req_ready/rsp delay ->
//    x/y sequence gapless, no dup/drop; req addr/valid stable while stalled.
//  5 start pulsed at pixel 100 -> ignored.
//    rst_n low at pixel 1000 with read outstanding -> outputs 0, late rsp dropped.
//    New start -> complete correct frame.
//  6 Macro on: frame_crc == bench CRC model for frames of test 2/3.
//    Macro off: frame_crc == 0 throughout.

Source files
------------

// File: rtl/fb_scanout.sv
// ---------------------------------------------------------------------------
// fb_scanout
//
// Scans a 1bpp framebuffer out of memory and streams it as one pixel per
// cycle in raster order.  Pixel (x,y) lives in byte base + y*PITCH + x/8,
// bit x%8, so a little-endian 32-bit word holds 32 consecutive pixels of a
// row with bit i = pixel (x%32 == i).  Rows are contiguous (PITCH equals the
// row size in bytes), which lets the fetch address simply advance by one
// word after every emitted word.
//
// The block fetches one word, emits its 32 pixels, then fetches the next.
// Fetch and emit never overlap and at most one read is outstanding.
//
// Optional feature (macro FB_SCANOUT_CRC_EN):
//   defined     -> frame_crc carries a CRC-32 (poly 0x04C11DB7, init all-ones,
//                  MSB-first, one bit per accepted pixel, final inversion),
//                  captured when the last pixel of the frame is accepted.
//   not defined -> frame_crc is tied to zero and no CRC logic exists.
//
// Ports
//   clk            in   clock, all state on the rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   pulse: scan one frame (ignored unless idle)
//   fb_base        in   framebuffer byte base, sampled on accepted start
//   busy           out  scan in progress (fetching or emitting)
//   done           out  one-cycle pulse after the last pixel is accepted
//   mem_req_valid  out  word read request
//   mem_req_ready  in   memory accepts the request
//   mem_req_addr   out  4-aligned byte address of the requested word
//   mem_rsp_valid  in   read data return
//   mem_rsp_data   in   returned word
//   pix_valid      out  pixel available
//   pix_ready      in   consumer accepts the pixel
//   pix_data       out  pixel value
//   pix_x / pix_y  out  pixel column / row
//   pix_sof        out  first pixel of the frame
//   pix_eol        out  last pixel of a row
//   pix_eof        out  last pixel of the frame
//   frame_crc      out  CRC of the last completed frame (zero when disabled)
// ---------------------------------------------------------------------------
module fb_scanout #(
    parameter int FB_WIDTH  = 64,
    parameter int FB_HEIGHT = 64,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              busy,
    output logic              done,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic [15:0]       pix_x,
    output logic [15:0]       pix_y,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic [31:0]       frame_crc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [15:0]       X_MAX      = 16'(FB_WIDTH - 1);
    localparam logic [15:0]       Y_MAX      = 16'(FB_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;         // address of the word being fetched/emitted
    logic              outstanding_q, outstanding_d;
    logic [31:0]       sr_q, sr_d;             // pixel shift register, LSB is the current pixel
    logic [4:0]        bit_q, bit_d;           // pixel index inside the current word
    logic [15:0]       x_q, x_d;
    logic [15:0]       y_q, y_d;

    logic start_fire;
    logic pix_fire;
    logic last_x;
    logic last_y;
    logic word_last;
    logic frame_last;

    assign start_fire = (state_q == S_IDLE) && start;
    assign pix_fire   = (state_q == S_EMIT) && pix_ready;
    assign last_x     = (x_q == X_MAX);
    assign last_y     = (y_q == Y_MAX);
    assign word_last  = (bit_q == 5'd31);
    // FB_WIDTH is a multiple of 32, so the frame's last pixel is always the
    // last bit of a word.
    assign frame_last = pix_fire && word_last && last_x && last_y;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        outstanding_d = outstanding_q;
        sr_d          = sr_q;
        bit_d         = bit_q;
        x_d           = x_q;
        y_d           = y_q;

        case (state_q)
            S_IDLE: begin
                if (start_fire) begin
                    state_d = S_REQ;
                    addr_d  = fb_base & ALIGN_MASK;
                    x_d     = '0;
                    y_d     = '0;
                    bit_d   = '0;
                end
            end

            S_REQ: begin
                // valid and address are held by staying here until ready.
                if (mem_req_ready) begin
                    state_d       = S_WAIT;
                    outstanding_d = 1'b1;
                end
            end

            S_WAIT: begin
                // Only a response matching our outstanding read is taken;
                // anything arriving in another state is simply ignored.
                if (mem_rsp_valid && outstanding_q) begin
                    state_d       = S_EMIT;
                    outstanding_d = 1'b0;
                    sr_d          = mem_rsp_data;
                    bit_d         = '0;
                end
            end

            S_EMIT: begin
                if (pix_ready) begin
                    sr_d  = {1'b0, sr_q[31:1]};
                    bit_d = bit_q + 5'd1;
                    if (last_x) begin
                        x_d = '0;
                        y_d = last_y ? 16'd0 : y_q + 16'd1;
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                    if (word_last) begin
                        addr_d  = addr_q + WORD_BYTES;
                        state_d = frame_last ? S_DONE : S_REQ;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too (not just the FSM)
            // because every output, including pixel position, must read 0.
            state_q       <= S_IDLE;
            addr_q        <= '0;
            outstanding_q <= 1'b0;
            sr_q          <= '0;
            bit_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its neighbours.
            state_q       <= state_d;
            addr_q        <= addr_d;
            outstanding_q <= outstanding_d;
            sr_q          <= sr_d;
            bit_q         <= bit_d;
            x_q           <= x_d;
            y_q           <= y_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all decoded from registered state, so they are stable while
    // a handshake is stalled)
    // -----------------------------------------------------------------------
    assign busy          = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_EMIT);
    assign done          = (state_q == S_DONE);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = mem_req_valid ? addr_q : '0;
    assign pix_valid     = (state_q == S_EMIT);
    assign pix_data      = pix_valid & sr_q[0];
    assign pix_x         = x_q;
    assign pix_y         = y_q;
    assign pix_sof       = pix_valid && (x_q == 16'd0) && (y_q == 16'd0);
    assign pix_eol       = pix_valid && last_x;
    assign pix_eof       = pix_valid && last_x && last_y;

    // -----------------------------------------------------------------------
    // Optional frame CRC
    // -----------------------------------------------------------------------
`ifdef FB_SCANOUT_CRC_EN
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    logic [31:0] crc_q, crc_d;
    logic [31:0] frame_crc_q, frame_crc_d;

    // One MSB-first CRC-32 step for a single pixel bit.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? CRC_POLY : 32'h0);
    endfunction

    always_comb begin
        crc_d       = crc_q;
        frame_crc_d = frame_crc_q;
        if (start_fire) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (pix_fire) begin
            crc_d = crc_step(crc_q, sr_q[0]);
            // Captured on the last accepted pixel so it is valid while done pulses.
            if (frame_last) begin
                frame_crc_d = ~crc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q       <= '0;
            frame_crc_q <= '0;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 32'h0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// ---------------------------------------------------------------------------
// tb_fb_scanout
//
// Directed bench for fb_scanout.  A word-addressed memory model answers the
// read port with programmable request/response delays, and a pixel sink
// consumes the stream with optional random back-pressure.  Both compare
// every transfer against the framebuffer contents the bench wrote, and the
// main sequence checks the per-frame tallies.
// ---------------------------------------------------------------------------
module tb_fb_scanout;

    localparam int W      = 64;
    localparam int H      = 64;
    localparam int PITCH  = W / 8;
    localparam int NPIX   = W * H;
    localparam int NWORDS = NPIX / 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] fb_base = 32'h0;
    logic        busy, done;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_data;
    logic [15:0] pix_x, pix_y;
    logic        pix_sof, pix_eol, pix_eof;
    logic [31:0] frame_crc;

    always #5 clk = ~clk;

    fb_scanout dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .fb_base       (fb_base),
        .busy          (busy),
        .done          (done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .pix_eof       (pix_eof),
        .frame_crc     (frame_crc)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 16 KB, word indexed by address bits [13:2].
    logic [31:0] mem [0:4095];

    // Knobs and per-frame bookkeeping shared with the models.
    bit          rand_ready  = 1'b0;
    int unsigned req_dly_max = 0;
    int unsigned rsp_dly_min = 0;
    int unsigned rsp_dly_max = 0;
    logic [31:0] exp_base = 32'h0;
    logic [31:0] last_req_addr = 32'h0;
    int          req_idx = 0;
    int          mem_err = 0;
    int          pix_idx = 0;
    int          pix_err = 0;
    int          ones = 0;
    logic [15:0] one_x = 16'h0, one_y = 16'h0;
    int          sof_cnt = 0, eol_cnt = 0, eof_cnt = 0;
    int          eof_cyc = -1;

    // Expected pixel straight from the byte-addressed layout.
    function automatic logic exp_pix(input logic [31:0] base, input int x, input int y);
        logic [31:0] a;
        logic [31:0] w;
        a = base + 32'(y * PITCH) + 32'(x / 8);
        w = mem[a[13:2]];
        return w[{a[1:0], 3'b000} + 5'(x % 8)];
    endfunction

    function automatic logic [31:0] crc_model(input logic [31:0] base);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                fb = c[31] ^ exp_pix(base, x, y);
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
            end
        end
        return ~c;
    endfunction

    // ---------------------------------------------------------------------
    // Memory slave (acts on falling edges; DUT samples on rising edges)
    // ---------------------------------------------------------------------
    int          req_wait = 0;
    int          rsp_cnt = 0;
    bit          rsp_pending = 1'b0;
    logic [31:0] rsp_word = 32'h0;
    bit          req_stall_prev = 1'b0;
    logic [31:0] req_addr_prev = 32'h0;
    bit          rsp_chk = 1'b0;

    always @(negedge clk) begin
        // A response given while scanning must show up as pixels next cycle.
        if (rsp_chk && rst_n && !pix_valid) mem_err++;
        rsp_chk       = 1'b0;
        mem_rsp_valid = 1'b0;
        // The response channel keeps running through reset so late data arrives.
        if (rsp_pending) begin
            if (rsp_cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = rsp_word;
                rsp_pending   = 1'b0;
                rsp_chk       = busy;
            end else begin
                rsp_cnt--;
            end
        end
        mem_req_ready = 1'b0;
        if (!rst_n) begin
            req_stall_prev = 1'b0;
        end else begin
            if (req_stall_prev && (!mem_req_valid || mem_req_addr !== req_addr_prev)) mem_err++;
            if (mem_req_valid && pix_valid) mem_err++;
            req_stall_prev = 1'b0;
            if (mem_req_valid) begin
                if (req_wait == 0) begin
                    mem_req_ready = 1'b1;
                    if (mem_req_addr !== exp_base + 32'(req_idx * 4)) mem_err++;
                    if (rsp_pending) mem_err++;
                    last_req_addr = mem_req_addr;
                    req_idx++;
                    rsp_word    = mem[mem_req_addr[13:2]];
                    rsp_pending = 1'b1;
                    rsp_cnt     = int'($urandom_range(rsp_dly_max, rsp_dly_min));
                    req_wait    = int'($urandom_range(req_dly_max, 0));
                end else begin
                    req_wait--;
                    req_stall_prev = 1'b1;
                    req_addr_prev  = mem_req_addr;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Pixel sink
    // ---------------------------------------------------------------------
    bit          pix_stall_prev = 1'b0;
    logic [35:0] pix_prev = '0;

    always @(negedge clk) begin
        logic [35:0] got;
        logic [35:0] want;
        int          ex, ey;
        got = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
        if (!rst_n) begin
            pix_stall_prev = 1'b0;
            pix_ready      = 1'b0;
        end else begin
            if (pix_stall_prev && (!pix_valid || got !== pix_prev)) pix_err++;
            pix_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            if (pix_valid && pix_ready) begin
                ex   = pix_idx % W;
                ey   = pix_idx / W;
                want = {exp_pix(exp_base, ex, ey), 16'(ex), 16'(ey),
                        pix_idx == 0, ex == W - 1, pix_idx == NPIX - 1};
                if (got !== want) begin
                    if (pix_err == 0)
                        $display("first bad pixel idx %0d got %h want %h", pix_idx, got, want);
                    pix_err++;
                end
                if (pix_data) begin
                    ones++;
                    one_x = pix_x;
                    one_y = pix_y;
                end
                if (pix_sof) sof_cnt++;
                if (pix_eol) eol_cnt++;
                if (pix_eof) begin
                    eof_cnt++;
                    eof_cyc = cyc;
                end
                pix_idx++;
            end
            pix_stall_prev = pix_valid && !pix_ready;
            pix_prev       = got;
        end
    end

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"},
              64'({busy, done, mem_req_valid, pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
                   pix_x, pix_y}), 64'd0);
        check({tag, "_addr_crc"}, {mem_req_addr, frame_crc}, 64'd0);
    endtask

    task automatic do_start(input logic [31:0] base);
        exp_base = base;
        req_idx  = 0;
        req_wait = 0;
        mem_err  = 0;
        pix_idx  = 0;
        pix_err  = 0;
        ones     = 0;
        sof_cnt  = 0;
        eol_cnt  = 0;
        eof_cnt  = 0;
        eof_cyc  = -1;
        fb_base  = base;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        fb_base  = 32'hDEAD_BEE0;  // must not be resampled mid-frame
        check("start_to_req_latency", 64'({busy, mem_req_valid}), 64'd3);
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        dcyc = cyc;
    endtask

    task automatic run_frame(input string tag, input logic [31:0] base);
        int dcyc;
        do_start(base);
        wait_done(tag, dcyc);
        check({tag, "_pix_errors"}, 64'(pix_err), 64'd0);
        check({tag, "_pix_count"}, 64'(pix_idx), 64'(NPIX));
        check({tag, "_mem_errors"}, 64'(mem_err), 64'd0);
        check({tag, "_req_count"}, 64'(req_idx), 64'(NWORDS));
        check({tag, "_done_latency"}, 64'(dcyc - eof_cyc), 64'd1);
`ifdef FB_SCANOUT_CRC_EN
        check({tag, "_crc"}, 64'(frame_crc), 64'(crc_model(base)));
`else
        check({tag, "_crc_off"}, 64'(frame_crc), 64'd0);
`endif
        // start coinciding with done is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_on_done"}, 64'({busy, mem_req_valid, done}), 64'd0);
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        int n;
        bit reached;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

        // 1: reset
        rst_n = 1'b0;
        repeat (10) tick();
        check_idle_outputs("t1_in_reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("t1_after_reset");

        // 2: single lit pixel at (0,0)
        mem[32'h2000 >> 2] = 32'h0000_0001;
        run_frame("t2", 32'h2000);
        check("t2_ones", 64'(ones), 64'd1);
        check("t2_one_xy", 64'({one_x, one_y}), 64'd0);
        check("t2_markers", 64'({16'(sof_cnt), 16'(eol_cnt), 16'(eof_cnt)}), 64'h0001_0040_0001);

        // 3: single lit pixel at x=37, y=5 via word 0x202C bit 5
        mem[32'h2000 >> 2] = 32'h0;
        mem[32'h202C >> 2] = 32'h0000_0020;
        run_frame("t3", 32'h2000);
        check("t3_ones", 64'(ones), 64'd1);
        check("t3_one_xy", 64'({one_x, one_y}), {32'd0, 16'd37, 16'd5});
        check("t3_last_req_addr", 64'(last_req_addr), 64'h21FC);

        // 4: random image, random back-pressure and memory delays
        for (int i = 0; i < NWORDS; i++) mem[(32'h2000 >> 2) + i] = $urandom;
        rand_ready  = 1'b1;
        req_dly_max = 5;
        rsp_dly_min = 0;
        rsp_dly_max = 5;
        run_frame("t4", 32'h2000);

        // 5: ignored start, reset with a read outstanding, then a clean frame
        for (int i = 0; i < NWORDS; i++) mem[(32'h3000 >> 2) + i] = $urandom;
        rand_ready  = 1'b0;
        req_dly_max = 2;
        rsp_dly_min = 5;
        rsp_dly_max = 5;
        do_start(32'h3000);
        n = 0;
        while (pix_idx < 100 && n < 5000) begin
            tick();
            n++;
        end
        fb_base = 32'h2000;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("t5_busy_after_ignored_start", 64'(busy), 64'd1);
        n = 0;
        reached = 1'b0;
        while (!reached && n < 20000) begin
            tick();
            n++;
            reached = (pix_idx >= 1000) && rsp_pending && busy && !mem_req_valid && !pix_valid;
        end
        check("t5_read_outstanding_at_1000", 64'(reached), 64'd1);
        check("t5_partial_pix_errors", 64'(pix_err), 64'd0);
        check("t5_partial_mem_errors", 64'(mem_err), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_midframe_reset");
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        while (rsp_pending && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("t5_late_rsp_dropped", 64'({pix_valid, busy, mem_req_valid}), 64'd0);
        rsp_dly_min = 0;
        rsp_dly_max = 3;
        rand_ready  = 1'b1;
        run_frame("t5_restart", 32'h3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
